alu_execute: RTL and testbench

//  Execute stage downstream of the instruction decoder. Consumes the 6-bit alu_control code,

---
 rtl/alu_execute.sv | 153 +++++++++++++++
 tb/tb_alu_execute.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/alu_execute.sv
// Execute stage: one-cycle ALU ops plus an iterative 1-bit-per-cycle shifter,
// with a valid/ready handshake on both the operand side and the result side.
module alu_execute #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        alu_control,
  input  logic [XLEN-1:0]   op_a,
  input  logic [XLEN-1:0]   op_b,
  input  logic [XLEN-1:0]   imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   result,
  output logic              zero,
  output logic              illegal_op,
  output logic [1:0]        dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both
  // high; a producer holds its payload stable while valid is high and ready is low.

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_DONE = 2'd2} state_e;

  localparam logic [1:0] SH_LL = 2'd0;
  localparam logic [1:0] SH_RL = 2'd1;
  localparam logic [1:0] SH_RA = 2'd2;

  state_e               state_q, state_d;
  logic [XLEN-1:0]      work_q, work_d;
  logic [SHAMT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]           kind_q, kind_d;
  logic [XLEN-1:0]      result_q, result_d;
  logic                 zero_q, zero_d;
  logic                 illegal_q, illegal_d;

  logic [XLEN-1:0]      opb;
  logic [SHAMT_W-1:0]   shamt;
  logic [XLEN-1:0]      alu_res;
  logic                 legal;
  logic                 is_shift;
  logic [1:0]           kind;
  logic [XLEN-1:0]      work_step;

  // R-type codes occupy 0..9; everything else that is legal takes the immediate.
  always_comb begin
    opb      = (alu_control <= 6'd9) ? op_b : imm;
    shamt    = opb[SHAMT_W-1:0];
    alu_res  = '0;
    legal    = 1'b1;
    is_shift = 1'b0;
    kind     = SH_LL;
    case (alu_control)
      6'b000000, 6'b111111: alu_res = op_a + opb;
      6'b001000:            alu_res = op_a - opb;
      6'b000001, 6'b111110: alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(opb)};
      6'b000010, 6'b111101: alu_res = {{(XLEN-1){1'b0}}, op_a < opb};
      6'b000011, 6'b111100: alu_res = op_a & opb;
      6'b000100, 6'b111011: alu_res = op_a | opb;
      6'b000101, 6'b111010: alu_res = op_a ^ opb;
      6'b000110, 6'b111001: begin is_shift = 1'b1; kind = SH_LL; end
      6'b000111, 6'b111000: begin is_shift = 1'b1; kind = SH_RL; end
      6'b001001, 6'b101010: begin is_shift = 1'b1; kind = SH_RA; end
      default:              legal = 1'b0;
    endcase
  end

  always_comb begin
    case (kind_q)
      SH_LL:   work_step = {work_q[XLEN-2:0], 1'b0};
      SH_RL:   work_step = {1'b0, work_q[XLEN-1:1]};
      default: work_step = {work_q[XLEN-1], work_q[XLEN-1:1]};
    endcase
  end

  always_comb begin
    state_d   = state_q;
    work_d    = work_q;
    cnt_d     = cnt_q;
    kind_d    = kind_q;
    result_d  = result_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          illegal_d = ~legal;
          state_d   = S_DONE;
          if (!legal) begin
            result_d = '0;
            zero_d   = 1'b1;
          end else if (is_shift && shamt != '0) begin
            work_d  = op_a;
            cnt_d   = shamt;
            kind_d  = kind;
            state_d = S_SHIFT;
          end else if (is_shift) begin
            result_d = op_a;
            zero_d   = (op_a == '0);
          end else begin
            result_d = alu_res;
            zero_d   = (alu_res == '0);
          end
        end
      end
      S_SHIFT: begin
        work_d = work_step;
        cnt_d  = cnt_q - 1'b1;
        // The last step lands straight in the result register.
        if (cnt_q == {{(SHAMT_W-1){1'b0}}, 1'b1}) begin
          result_d = work_step;
          zero_d   = (work_step == '0);
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      work_q    <= '0;
      cnt_q     <= '0;
      kind_q    <= SH_LL;
      result_q  <= '0;
      zero_q    <= 1'b1;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      work_q    <= work_d;
      cnt_q     <= cnt_d;
      kind_q    <= kind_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
    end
  end

  assign in_ready   = (state_q == S_IDLE);
  assign out_valid  = (state_q == S_DONE);
  assign result     = result_q;
  assign zero       = zero_q;
  assign illegal_op = illegal_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_alu_execute.sv
// Bench for alu_execute: directed scenarios plus random ops checked against an
// arithmetic reference model, with a result scoreboard.
module tb_alu_execute;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic [5:0]      alu_control;
  logic [XLEN-1:0] op_a, op_b, imm;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;
  logic            illegal_op;
  logic [1:0]      dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  logic [XLEN-1:0] exp_q[$];

  alu_execute #(.XLEN(XLEN), .SHAMT_W(5)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .alu_control(alu_control), .op_a(op_a), .op_b(op_b), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .zero(zero), .illegal_op(illegal_op), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: result, illegal flag and cycles-to-valid from the ISA rules.
  function automatic void ref_model(input logic [5:0] code, input logic [31:0] a,
                                    input logic [31:0] b, input logic [31:0] im,
                                    output logic [31:0] r, output logic ill, output int lat);
    logic [31:0] bb;
    int sh;
    bb  = (code <= 6'd9) ? b : im;
    sh  = int'(bb % 32);
    r   = 32'd0;
    ill = 1'b0;
    lat = 1;
    case (code)
      6'b000000, 6'b111111: r = a + bb;
      6'b001000:            r = a - bb;
      6'b000001, 6'b111110: r = ($signed(a) < $signed(bb)) ? 32'd1 : 32'd0;
      6'b000010, 6'b111101: r = (a < bb) ? 32'd1 : 32'd0;
      6'b000011, 6'b111100: r = a & bb;
      6'b000100, 6'b111011: r = a | bb;
      6'b000101, 6'b111010: r = a ^ bb;
      6'b000110, 6'b111001: begin r = a << sh; lat = 1 + sh; end
      6'b000111, 6'b111000: begin r = a >> sh; lat = 1 + sh; end
      6'b001001, 6'b101010: begin r = $unsigned($signed(a) >>> sh); lat = 1 + sh; end
      default:              ill = 1'b1;
    endcase
  endfunction

  // driver: issue one op, wait for the result, apply backpressure, hand off
  task automatic run_op(input logic [5:0] code, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] im, input int stall);
    logic [31:0] er;
    logic        ei;
    int          el;
    int          lat;
    logic [31:0] got;
    ref_model(code, a, b, im, er, ei, el);
    exp_q.push_back(er);
    @(negedge clk);
    check_eq("in_ready_idle", 32'(in_ready), 32'd1);
    in_valid = 1'b1; alu_control = code; op_a = a; op_b = b; imm = im;
    @(negedge clk);
    in_valid = 1'b0; alu_control = 6'($urandom); op_a = $urandom; op_b = $urandom; imm = $urandom;
    lat = 1;
    while (!out_valid && lat < 40) begin
      check_eq("in_ready_busy", 32'(in_ready), 32'd0);
      @(negedge clk);
      lat++;
    end
    check_eq("latency", 32'(lat), 32'(el));
    got = exp_q.pop_front();
    check_eq("out_valid", 32'(out_valid), 32'd1);
    check_eq("result", result, got);
    check_eq("zero", 32'(zero), 32'(got == 32'd0));
    check_eq("illegal_op", 32'(illegal_op), 32'(ei));
    repeat (stall) begin
      @(negedge clk);
      check_eq("hold_valid", 32'(out_valid), 32'd1);
      check_eq("hold_result", result, got);
      check_eq("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_eq("handoff_valid", 32'(out_valid), 32'd0);
    check_eq("handoff_in_ready", 32'(in_ready), 32'd1);
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    check_eq({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check_eq({tag, "_result"}, result, 32'd0);
    check_eq({tag, "_zero"}, 32'(zero), 32'd1);
    check_eq({tag, "_illegal"}, 32'(illegal_op), 32'd0);
  endtask

  logic [5:0] codes [19] = '{6'b000000, 6'b000001, 6'b000010, 6'b000011, 6'b000100,
                             6'b000101, 6'b000110, 6'b000111, 6'b001000, 6'b001001,
                             6'b111111, 6'b111110, 6'b111101, 6'b111100, 6'b111011,
                             6'b111010, 6'b111001, 6'b111000, 6'b101010};

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int seen_valid;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    alu_control = '0; op_a = '0; op_b = '0; imm = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_state("reset");
    reset = 1'b0;

    run_op(6'b000000, 32'd5, 32'd7, 32'd0, 0);
    run_op(6'b001000, 32'd0, 32'd1, 32'd0, 0);
    run_op(6'b000001, 32'hFFFF_FFFF, 32'd1, 32'd0, 0);
    run_op(6'b000010, 32'hFFFF_FFFF, 32'd1, 32'd0, 0);
    run_op(6'b101010, 32'h8000_0000, 32'd0, 32'd31, 1);
    run_op(6'b111100, 32'h0000_F0F0, 32'd0, 32'h0000_0FF0, 5);
    run_op(6'b010101, 32'd3, 32'd4, 32'd5, 1);
    run_op(6'b111111, 32'd1, 32'd0, 32'hFFFF_FFFF, 0);
    run_op(6'b000110, 32'h1234_5678, 32'hFFFF_FFE0, 32'd0, 0);
    run_op(6'b111000, 32'h8000_0001, 32'd0, 32'h0000_0021, 0);

    // reset in the middle of a long shift abandons it
    @(negedge clk);
    in_valid = 1'b1; alu_control = 6'b000110; op_a = 32'h0000_0F0F; op_b = 32'd20;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_reset_state("mid_shift_reset");
    seen_valid = 0;
    repeat (25) begin
      @(negedge clk);
      if (out_valid) seen_valid++;
    end
    check_eq("no_stale_result", 32'(seen_valid), 32'd0);
    check_eq("no_stale_value", result, 32'd0);

    for (int i = 0; i < 60; i++) begin
      logic [5:0] c;
      c = ($urandom_range(0, 7) == 0) ? 6'($urandom) : codes[$urandom_range(0, 18)];
      run_op(c, pick_val(), pick_val(), pick_val(), $urandom_range(0, 3));
    end

    check_eq("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
